bram_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 6 +
 rtl/bram_arb_rr.sv | 16 +
 rtl/bram_arbiter.sv | 92 +++++++++
 tb/tb_bram_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state, requester count and owner index type for bram_arbiter
package bram_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  typedef logic [$clog2(NUM_REQ)-1:0] owner_t;
endpackage

// File: rtl/bram_arb_rr.sv
// bram_arb_rr: one-hot burst winner; BRAM_ARB_FIXED_PRIO_EN makes requester 0 always win ties
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  owner_t             i_ptr,
  output logic [NUM_REQ-1:0] o_win
);
`ifdef BRAM_ARB_FIXED_PRIO_EN
  owner_t w_unused;
  assign w_unused = i_ptr;
  assign o_win = i_req[0] ? 2'b01 : i_req;
`else
  assign o_win = (i_req == 2'b11) ? (i_ptr ? 2'b10 : 2'b01) : i_req;
`endif
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin burst arbiter for two agents sharing one single-port BRAM (BRAM_ARB_FIXED_PRIO_EN selects fixed priority)
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDRESS_DEPTH = 4092,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_BURST     = 16,
  localparam int AW = $clog2(ADDRESS_DEPTH),
  localparam int LW = $clog2(MAX_BURST)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     req,
  input  logic [1:0]                     wr,
  input  logic [1:0][AW-1:0]             start_addr,
  input  logic [1:0][LW-1:0]             len,
  input  logic [1:0][DATA_WIDTH-1:0]     wdata,
  output logic [1:0]                     gnt,
  output logic [1:0]                     wack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rvalid,
  output logic [1:0]                     done,
  output logic                           bram_wr,
  output logic [DATA_WIDTH-1:0]          bram_data,
  output logic [AW-1:0]                  bram_address,
  input  logic [DATA_WIDTH-1:0]          bram_q
);
  state_t          r_state;
  logic [1:0]      r_gnt;
  logic [1:0]      r_rvalid;
  owner_t          r_own;
  owner_t          r_ptr;
  logic            r_cur_wr;
  logic [AW-1:0]   r_cur_addr;
  logic [LW-1:0]   r_cnt;
  logic [1:0]      w_win;
  owner_t          w_own;
  logic            w_burst;

  bram_arb_rr u_rr (.i_req(req), .i_ptr(r_ptr), .o_win(w_win));

  assign w_own   = owner_t'(w_win[1]);
  assign w_burst = (r_state == BURST);

  // The address is not advanced on the last beat so it holds outside bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_own      <= '0;
      r_ptr      <= '0;
      r_cur_wr   <= 1'b0;
      r_cur_addr <= '0;
      r_cnt      <= '0;
    end else begin
      r_rvalid <= (w_burst && !r_cur_wr) ? r_gnt : '0;
      case (r_state)
        IDLE: if (|req) begin
          r_state    <= BURST;
          r_gnt      <= w_win;
          r_own      <= w_own;
          r_cur_wr   <= wr[w_own];
          r_cur_addr <= start_addr[w_own];
          r_cnt      <= len[w_own];
        end
        BURST: if (r_cnt == '0) r_state <= DONE;
        else begin
          r_cnt      <= r_cnt - 1'b1;
          r_cur_addr <= (r_cur_addr == AW'(ADDRESS_DEPTH - 1)) ? '0 : r_cur_addr + 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
          r_ptr   <= ~r_own;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign wack         = (w_burst && r_cur_wr) ? r_gnt : '0;
  assign done         = (r_state == DONE) ? r_gnt : '0;
  assign rvalid       = r_rvalid;
  assign rdata        = |r_rvalid ? bram_q : '0;
  assign bram_wr      = w_burst && r_cur_wr;
  assign bram_data    = w_burst ? wdata[r_own] : '0;
  assign bram_address = r_cur_addr;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of bram_arbiter against a behavioural BRAM
module tb_bram_arbiter;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req, wr, gnt, wack, rvalid, done;
  logic [1:0][11:0]  start_addr;
  logic [1:0][3:0]   len;
  logic [1:0][15:0]  wdata;
  logic [15:0]       rdata, bram_data, bram_q;
  logic              bram_wr;
  logic [11:0]       bram_address;
  logic [15:0]       mem [0:4091];
  logic [11:0]       r_ra;
  logic [1:0]        exp_g;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .start_addr(start_addr), .len(len),
    .wdata(wdata), .gnt(gnt), .wack(wack), .rdata(rdata), .rvalid(rvalid), .done(done),
    .bram_wr(bram_wr), .bram_data(bram_data), .bram_address(bram_address), .bram_q(bram_q)
  );

  always @(posedge clk) begin
    if (bram_wr) mem[bram_address] <= bram_data;
    r_ra <= bram_address;
  end
  assign bram_q = mem[r_ra];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 0);
    chk({tag, " wack"}, 32'(wack), 0);
    chk({tag, " rvalid"}, 32'(rvalid), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " rdata"}, 32'(rdata), 0);
    chk({tag, " bram_wr"}, 32'(bram_wr), 0);
    chk({tag, " bram_data"}, 32'(bram_data), 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; wr = '0; start_addr = '0; len = '0; wdata = '0;
    tick; tick;
    rst = 1'b0;
    chk_idle_outputs("reset");
    chk("reset addr", 32'(bram_address), 0);

    // write burst: req0, addr 10, len 3
    req = 2'b01; wr = 2'b01; start_addr[0] = 12'd10; len[0] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("wr gnt", 32'(gnt), 32'h1);
      chk("wr wack", 32'(wack), 32'h1);
      chk("wr addr", 32'(bram_address), 32'(10 + k));
      chk("wr done low", 32'(done), 0);
      wdata[0] = 16'hA0 + 16'(k);
    end
    tick;
    chk("wr done", 32'(done), 32'h1);
    chk("wr gnt in done", 32'(gnt), 32'h1);
    chk("wr bram_wr in done", 32'(bram_wr), 0);
    req = 2'b00;
    tick;
    chk("wr idle gnt", 32'(gnt), 0);
    for (int k = 0; k < 4; k++) chk("wr mem", 32'(mem[10 + k]), 32'(16'hA0 + k));

    // read back: req1, addr 10, len 3
    req = 2'b10; wr = 2'b00; start_addr[1] = 12'd10; len[1] = 4'd3;
    tick;
    chk("rd gnt", 32'(gnt), 32'h2);
    chk("rd rvalid first", 32'(rvalid), 0);
    chk("rd wack", 32'(wack), 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rd rvalid", 32'(rvalid), 32'h2);
      chk("rd rdata", 32'(rdata), 32'(16'hA0 + k));
      chk("rd done", 32'(done), (k == 3) ? 32'h2 : 0);
    end
    req = 2'b00;
    tick;
    chk("rd idle rvalid", 32'(rvalid), 0);

    // wrap: write 4090..4091,0,1
    req = 2'b01; wr = 2'b01; start_addr[0] = 12'd4090; len[0] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("wrap addr", 32'(bram_address), (k < 2) ? 32'(4090 + k) : 32'(k - 2));
      wdata[0] = 16'h50 + 16'(k);
    end
    tick;
    req = 2'b00;
    tick;
    chk("wrap mem 4090", 32'(mem[4090]), 32'h50);
    chk("wrap mem 4091", 32'(mem[4091]), 32'h51);
    chk("wrap mem 0", 32'(mem[0]), 32'h52);
    chk("wrap mem 1", 32'(mem[1]), 32'h53);

    // len 0 read of address 0; req dropped mid-burst
    req = 2'b01; wr = 2'b00; start_addr[0] = 12'd0; len[0] = 4'd0;
    tick;
    req = 2'b00;
    chk("len0 gnt", 32'(gnt), 32'h1);
    chk("len0 addr", 32'(bram_address), 0);
    tick;
    chk("len0 rvalid", 32'(rvalid), 32'h1);
    chk("len0 rdata", 32'(rdata), 32'h52);
    chk("len0 done", 32'(done), 32'h1);
    tick;
    chk("len0 idle gnt", 32'(gnt), 0);
    chk("len0 idle rvalid", 32'(rvalid), 0);

    // simultaneous requests after reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 2'b11; wr = 2'b00; start_addr = '0; len = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tick;
      chk("rr gnt", 32'(gnt), 32'(exp_g));
      tick;
      chk("rr done", 32'(done), 32'(exp_g));
      tick;
      chk("rr idle gnt", 32'(gnt), 0);
      if (i == 3) req = 2'b00;
    end
    tick;

    // reset during beat 2 of an 8-beat write
    req = 2'b01; wr = 2'b01; start_addr[0] = 12'd100; len[0] = 4'd7;
    for (int k = 0; k < 3; k++) begin
      tick;
      wdata[0] = 16'hC0 + 16'(k);
    end
    rst = 1'b1; req = 2'b00;
    tick;
    rst = 1'b0;
    chk_idle_outputs("midrst");
    chk("midrst addr", 32'(bram_address), 0);
    tick;
    chk("midrst no done", 32'(done), 0);
    chk("midrst mem 100", 32'(mem[100]), 32'hC0);
    chk("midrst mem 101", 32'(mem[101]), 32'hC1);
    req = 2'b10; wr = 2'b00; start_addr[1] = 12'd100; len[1] = 4'd1;
    tick;
    chk("post gnt", 32'(gnt), 32'h2);
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("post rvalid", 32'(rvalid), 32'h2);
      chk("post rdata", 32'(rdata), 32'(16'hC0 + k));
    end
    chk("post done", 32'(done), 32'h2);
    req = 2'b00;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
